// File: rtl/opora_frame_loader_if.sv
// Receive byte stream from the Ethernet MAC into the opora frame loader.
// Latency: none, plain wires.
// Backpressure: none; the source cannot be stalled.
interface opora_frame_loader_if;
    logic [7:0] data;
    logic       valid;
    logic       sof;
    logic       eof;

    modport master (output data, valid, sof, eof);
    modport slave  (input  data, valid, sof, eof);
endinterface

// File: rtl/opora_frame_loader.sv
// Validates an opora frame (magic, length, checksum when OPORA_CHECKSUM_EN), buffers it, replays it as strobes.
// Latency: first opora_en 2 cycles after the accepting byte, then one strobe every GAP+1 cycles.
// Backpressure: none; rx bytes arriving during replay are dropped and the frame is skipped until its next sof.
module opora_frame_loader #(
    parameter int          NUM_OPORA = 200,
    parameter int          GAP       = 0,
    parameter logic [15:0] MAGIC     = 16'h4F50
) (
    input  logic                clke,
    input  logic                rst_n,
    opora_frame_loader_if.slave rx,
    output logic                opora_en,
    output logic [15:0]         OPORA,
    output logic                busy,
    output logic                load_done,
    output logic                err_len,
    output logic                err_sum
);
    localparam int            AW   = (NUM_OPORA > 1) ? $clog2(NUM_OPORA) : 1;
    localparam int            GW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [AW-1:0] LAST = AW'(NUM_OPORA - 1);

`ifdef OPORA_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, DROP, SEND} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DROP, SEND} state_t;
`endif

    state_t        state, state_nxt, start_state;
    logic [15:0]   ram [NUM_OPORA];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   sum, word;
    logic [7:0]    hi_byte;
    logic          phase, last_rd;
    logic          sof_v, frame_start, byte_take, word_wr, rd_issue, err_len_nxt;
`ifdef OPORA_CHECKSUM_EN
    logic          err_sum_nxt;
`endif

    assign sof_v    = rx.valid & rx.sof;
    assign word     = {hi_byte, rx.data};
    assign rd_issue = (state == SEND) && (gap_cnt == '0);
    // busy covers the SEND state plus the cycle of the final strobe
    assign busy     = (state == SEND) | opora_en;

    // where a sof byte leads: single-byte frames stay idle, wrong magic byte drops the frame
    always_comb begin
        start_state = DROP;
        if (rx.eof)
            start_state = IDLE;
        else if (rx.data == MAGIC[15:8])
            start_state = HDR;
    end

    // next-state and per-byte control decisions
    always_comb begin
        state_nxt   = state;
        err_len_nxt = 1'b0;
`ifdef OPORA_CHECKSUM_EN
        err_sum_nxt = 1'b0;
`endif
        frame_start = 1'b0;
        byte_take   = 1'b0;
        word_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (sof_v) begin
                    state_nxt   = start_state;
                    err_len_nxt = rx.eof;
                    frame_start = 1'b1;
                end
            end
            HDR: begin
                if (sof_v) begin
                    state_nxt   = start_state;
                    err_len_nxt = 1'b1;
                    frame_start = 1'b1;
                end else if (rx.valid) begin
                    if (rx.data != MAGIC[7:0]) begin
                        state_nxt = rx.eof ? IDLE : DROP;
                    end else if (rx.eof) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (sof_v) begin
                    state_nxt   = start_state;
                    err_len_nxt = 1'b1;
                    frame_start = 1'b1;
                end else if (rx.valid) begin
                    byte_take = 1'b1;
                    word_wr   = phase;
                    if (phase && (wr_ptr == LAST)) begin
`ifdef OPORA_CHECKSUM_EN
                        if (rx.eof) begin
                            err_len_nxt = 1'b1;
                            state_nxt   = IDLE;
                        end else begin
                            state_nxt = CSUM;
                        end
`else
                        if (rx.eof) begin
                            state_nxt = SEND;
                        end else begin
                            err_len_nxt = 1'b1;
                            state_nxt   = DROP;
                        end
`endif
                    end else if (rx.eof) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
`ifdef OPORA_CHECKSUM_EN
            CSUM: begin
                if (sof_v) begin
                    state_nxt   = start_state;
                    err_len_nxt = 1'b1;
                    frame_start = 1'b1;
                end else if (rx.valid) begin
                    byte_take = 1'b1;
                    if (!phase) begin
                        if (rx.eof) begin
                            err_len_nxt = 1'b1;
                            state_nxt   = IDLE;
                        end
                    end else if (!rx.eof) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = DROP;
                    end else if (word != sum) begin
                        err_sum_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
`endif
            DROP: begin
                if (rx.valid && rx.eof)
                    state_nxt = IDLE;
            end
            SEND: begin
                if (rd_issue && (rd_ptr == LAST))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register and registered error pulses
    always_ff @(posedge clke) begin
        if (!rst_n) begin
            state   <= IDLE;
            err_len <= 1'b0;
`ifdef OPORA_CHECKSUM_EN
            err_sum <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            err_len <= err_len_nxt;
`ifdef OPORA_CHECKSUM_EN
            err_sum <= err_sum_nxt;
`endif
        end
    end

`ifndef OPORA_CHECKSUM_EN
    assign err_sum = 1'b0;
`endif

    // byte pairing, write pointer and running sum for the frame being received
    always_ff @(posedge clke) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            sum     <= '0;
            hi_byte <= '0;
            phase   <= 1'b0;
        end else if (frame_start) begin
            wr_ptr <= '0;
            sum    <= '0;
            phase  <= 1'b0;
        end else begin
            if (byte_take) begin
                phase <= ~phase;
                if (!phase)
                    hi_byte <= rx.data;
            end
            if (word_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + word;
            end
        end
    end

    // coefficient buffer; a rejected frame may leave partial data that SEND never reaches
    always_ff @(posedge clke) begin
        if (word_wr)
            ram[wr_ptr] <= word;
    end

    // replay: registered RAM read drives OPORA together with its strobe
    always_ff @(posedge clke) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            gap_cnt   <= '0;
            opora_en  <= 1'b0;
            OPORA     <= '0;
            last_rd   <= 1'b0;
            load_done <= 1'b0;
        end else begin
            opora_en  <= rd_issue;
            last_rd   <= rd_issue && (rd_ptr == LAST);
            load_done <= last_rd;
            if (rd_issue) begin
                OPORA   <= ram[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
                gap_cnt <= GW'(GAP);
            end else if (state == SEND) begin
                gap_cnt <= gap_cnt - 1'b1;
            end else begin
                rd_ptr  <= '0;
                gap_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_opora_frame_loader.sv
// Directed bench for opora_frame_loader: a GAP=0 and a GAP=3 instance share one rx stream.
// Latency: checks strobe timing relative to the accepting byte.
// Backpressure: exercises frames arriving during replay and random rx_valid gaps.
module tb_opora_frame_loader;
    logic clke = 1'b0;
    logic rst_n;
    always #5 clke = ~clke;

    opora_frame_loader_if rx0 ();
    opora_frame_loader_if rx3 ();
    assign rx3.data  = rx0.data;
    assign rx3.valid = rx0.valid;
    assign rx3.sof   = rx0.sof;
    assign rx3.eof   = rx0.eof;

    logic        en0, busy0, ld0, el0, es0;
    logic        en3, busy3, ld3, el3, es3;
    logic [15:0] op0, op3;

    opora_frame_loader #(.NUM_OPORA(200), .GAP(0), .MAGIC(16'h4F50)) dut0 (
        .clke(clke), .rst_n(rst_n), .rx(rx0.slave),
        .opora_en(en0), .OPORA(op0), .busy(busy0), .load_done(ld0),
        .err_len(el0), .err_sum(es0));

    opora_frame_loader #(.NUM_OPORA(200), .GAP(3), .MAGIC(16'h4F50)) dut3 (
        .clke(clke), .rst_n(rst_n), .rx(rx3.slave),
        .opora_en(en3), .OPORA(op3), .busy(busy3), .load_done(ld3),
        .err_len(el3), .err_sum(es3));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clke) cyc <= cyc + 1;

    // event recorder, sampled on the falling edge
    logic [15:0] sv0[$], sv3[$];
    int          sc0[$], sc3[$];
    int          nel0 = 0, el_cyc0 = -1, nes0 = 0, es_cyc0 = -1;
    int          nld0 = 0, ld_cyc0 = -1, nld3 = 0, ld_cyc3 = -1;
    logic        busy_h0 [0:32767];
    always @(negedge clke) begin
        if (en0) begin sv0.push_back(op0); sc0.push_back(cyc); end
        if (en3) begin sv3.push_back(op3); sc3.push_back(cyc); end
        if (el0) begin nel0 = nel0 + 1; el_cyc0 = cyc; end
        if (es0) begin nes0 = nes0 + 1; es_cyc0 = cyc; end
        if (ld0) begin nld0 = nld0 + 1; ld_cyc0 = cyc; end
        if (ld3) begin nld3 = nld3 + 1; ld_cyc3 = cyc; end
        if (cyc < 32768) busy_h0[cyc] = busy0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] fq[$];
    int         tv;

    // header, 200 words base+1..base+200, trailer = sum + adj when the checksum is compiled in
    task automatic build(input logic [15:0] hdr, input logic [15:0] base, input logic [15:0] adj);
        logic [15:0] s, w;
        fq.delete();
        fq.push_back(hdr[15:8]);
        fq.push_back(hdr[7:0]);
        s = 16'h0;
        for (int i = 0; i < 200; i++) begin
            w = base + 16'(i + 1);
            s = s + w;
            fq.push_back(w[15:8]);
            fq.push_back(w[7:0]);
        end
        s = s + adj;
`ifdef OPORA_CHECKSUM_EN
        fq.push_back(s[15:8]);
        fq.push_back(s[7:0]);
`endif
    endtask

    task automatic send(input bit gaps);
        for (int i = 0; i < fq.size(); i++) begin
            rx0.data  = fq[i];
            rx0.sof   = (i == 0);
            rx0.eof   = (i == fq.size() - 1);
            rx0.valid = 1'b1;
            @(posedge clke); #1;
            rx0.valid = 1'b0;
            rx0.sof   = 1'b0;
            rx0.eof   = 1'b0;
            if (gaps && i < fq.size() - 1) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin @(posedge clke); #1; end
            end
        end
        tv = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clke); #1; end
    endtask

    task automatic wait_ld0(input int prev, input int budget);
        for (int k = 0; k < budget && nld0 == prev; k++) begin @(posedge clke); #1; end
        idle(2);
    endtask

    task automatic wait_ld3(input int prev, input int budget);
        for (int k = 0; k < budget && nld3 == prev; k++) begin @(posedge clke); #1; end
        idle(2);
    endtask

    task automatic do_reset;
        rx0.valid = 1'b0; rx0.sof = 1'b0; rx0.eof = 1'b0; rx0.data = 8'h00;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset;
        rx0.valid = 1'b0; rx0.sof = 1'b0; rx0.eof = 1'b0; rx0.data = 8'h00;
        rst_n = 1'b0;
        idle(3);
        n_cmp++;
        if ({en0, op0, busy0, ld0, el0, es0} !== 21'h0) begin
            n_fail++; $display("FAIL reset_out0: got %h expected 0", {en0, op0, busy0, ld0, el0, es0});
        end
        n_cmp++;
        if ({en3, op3, busy3, ld3, el3, es3} !== 21'h0) begin
            n_fail++; $display("FAIL reset_out3: got %h expected 0", {en3, op3, busy3, ld3, el3, es3});
        end
        rst_n = 1'b1;
        idle(3);
        n_cmp++;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy0); end
    endtask

    task automatic test_ramp;
        int s0, e0, x0, l0, n, bad, t, first, last;
        do_reset;
        s0 = sc0.size(); e0 = nel0; x0 = nes0; l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        t = tv;
        wait_ld0(l0, 1000);
        n = sc0.size() - s0;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv0[s0 + i] !== 16'(i + 1)) bad++;
        first = (n > 0) ? sc0[s0] : -1;
        last  = (n > 0) ? sc0[s0 + n - 1] : -1;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL ramp_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL ramp_values: got %0d bad expected 0", bad); end
        n_cmp++; if (first !== t + 1) begin n_fail++; $display("FAIL ramp_first_cycle: got %0d expected %0d", first, t + 1); end
        n_cmp++; if (last !== t + 200) begin n_fail++; $display("FAIL ramp_last_cycle: got %0d expected %0d", last, t + 200); end
        n_cmp++; if (ld_cyc0 !== t + 201) begin n_fail++; $display("FAIL ramp_done_cycle: got %0d expected %0d", ld_cyc0, t + 201); end
        n_cmp++; if (nld0 - l0 !== 1) begin n_fail++; $display("FAIL ramp_done_count: got %0d expected 1", nld0 - l0); end
        n_cmp++; if (nel0 - e0 !== 0) begin n_fail++; $display("FAIL ramp_err_len: got %0d expected 0", nel0 - e0); end
        n_cmp++; if (nes0 - x0 !== 0) begin n_fail++; $display("FAIL ramp_err_sum: got %0d expected 0", nes0 - x0); end
        n_cmp++; if (busy_h0[t - 1] !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_before: got %b expected 0", busy_h0[t - 1]); end
        n_cmp++; if (busy_h0[t] !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_start: got %b expected 1", busy_h0[t]); end
        n_cmp++; if (busy_h0[t + 200] !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_last: got %b expected 1", busy_h0[t + 200]); end
        n_cmp++; if (busy_h0[t + 201] !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_done: got %b expected 0", busy_h0[t + 201]); end
    endtask

    task automatic test_bad_header;
        int s0, e0, x0, l0, n, bad;
        do_reset;
        s0 = sc0.size(); e0 = nel0; x0 = nes0;
        build(16'h4F51, 16'h0000, 16'h0000);
        send(0);
        idle(250);
        n_cmp++; if (sc0.size() - s0 !== 0) begin n_fail++; $display("FAIL hdr_strobes: got %0d expected 0", sc0.size() - s0); end
        n_cmp++; if (nel0 - e0 !== 0) begin n_fail++; $display("FAIL hdr_err_len: got %0d expected 0", nel0 - e0); end
        n_cmp++; if (nes0 - x0 !== 0) begin n_fail++; $display("FAIL hdr_err_sum: got %0d expected 0", nes0 - x0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL hdr_busy: got %b expected 0", busy0); end
        s0 = sc0.size(); l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        wait_ld0(l0, 1000);
        n = sc0.size() - s0;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv0[s0 + i] !== 16'(i + 1)) bad++;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL hdr_next_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL hdr_next_values: got %0d bad expected 0", bad); end
    endtask

    task automatic test_early_eof;
        int s0, e0, x0, l0, n, bad, t;
        do_reset;
        s0 = sc0.size(); e0 = nel0; x0 = nes0;
        build(16'h4F50, 16'h0000, 16'h0000);
        while (fq.size() > 401) void'(fq.pop_back());
        send(0);
        t = tv;
        idle(250);
        n_cmp++; if (nel0 - e0 !== 1) begin n_fail++; $display("FAIL len_err_count: got %0d expected 1", nel0 - e0); end
        n_cmp++; if (el_cyc0 !== t) begin n_fail++; $display("FAIL len_err_cycle: got %0d expected %0d", el_cyc0, t); end
        n_cmp++; if (sc0.size() - s0 !== 0) begin n_fail++; $display("FAIL len_strobes: got %0d expected 0", sc0.size() - s0); end
        n_cmp++; if (nes0 - x0 !== 0) begin n_fail++; $display("FAIL len_err_sum: got %0d expected 0", nes0 - x0); end
        s0 = sc0.size(); l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        wait_ld0(l0, 1000);
        n = sc0.size() - s0;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv0[s0 + i] !== 16'(i + 1)) bad++;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL len_next_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL len_next_values: got %0d bad expected 0", bad); end
        n_cmp++; if (nld0 - l0 !== 1) begin n_fail++; $display("FAIL len_next_done: got %0d expected 1", nld0 - l0); end
    endtask

    task automatic test_checksum_and_gaps;
        int s0, e0, x0, l0, n, bad;
        do_reset;
`ifdef OPORA_CHECKSUM_EN
        begin
            int t;
            s0 = sc0.size(); e0 = nel0; x0 = nes0;
            build(16'h4F50, 16'h0000, 16'h0001);
            send(0);
            t = tv;
            idle(250);
            n_cmp++; if (nes0 - x0 !== 1) begin n_fail++; $display("FAIL sum_err_count: got %0d expected 1", nes0 - x0); end
            n_cmp++; if (es_cyc0 !== t) begin n_fail++; $display("FAIL sum_err_cycle: got %0d expected %0d", es_cyc0, t); end
            n_cmp++; if (sc0.size() - s0 !== 0) begin n_fail++; $display("FAIL sum_strobes: got %0d expected 0", sc0.size() - s0); end
            n_cmp++; if (nel0 - e0 !== 0) begin n_fail++; $display("FAIL sum_err_len: got %0d expected 0", nel0 - e0); end
        end
`endif
        s0 = sc0.size(); e0 = nel0; x0 = nes0; l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(1);
        wait_ld0(l0, 1000);
        n = sc0.size() - s0;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv0[s0 + i] !== 16'(i + 1)) bad++;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL gaps_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL gaps_values: got %0d bad expected 0", bad); end
        n_cmp++; if ((nel0 - e0) + (nes0 - x0) !== 0) begin
            n_fail++; $display("FAIL gaps_errors: got %0d expected 0", (nel0 - e0) + (nes0 - x0));
        end
    endtask

    task automatic test_gap3_ignore;
        int s3, l3, n, bad, badsp, t, first, last;
        do_reset;
        s3 = sc3.size(); l3 = nld3;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        t = tv;
        idle(5);
        build(16'h4F50, 16'h1000, 16'h0000);
        send(0);
        wait_ld3(l3, 2000);
        n = sc3.size() - s3;
        bad = 0; badsp = 0;
        for (int i = 0; i < n; i++) begin
            if (sv3[s3 + i] !== 16'(i + 1)) bad++;
            if (i > 0 && sc3[s3 + i] - sc3[s3 + i - 1] != 4) badsp++;
        end
        first = (n > 0) ? sc3[s3] : -1;
        last  = (n > 0) ? sc3[s3 + n - 1] : -1;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL gap3_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL gap3_values: got %0d bad expected 0", bad); end
        n_cmp++; if (badsp !== 0) begin n_fail++; $display("FAIL gap3_spacing: got %0d bad expected 0", badsp); end
        n_cmp++; if (first !== t + 1) begin n_fail++; $display("FAIL gap3_first_cycle: got %0d expected %0d", first, t + 1); end
        n_cmp++; if (last !== t + 797) begin n_fail++; $display("FAIL gap3_last_cycle: got %0d expected %0d", last, t + 797); end
        n_cmp++; if (ld_cyc3 !== t + 798) begin n_fail++; $display("FAIL gap3_done_cycle: got %0d expected %0d", ld_cyc3, t + 798); end
        s3 = sc3.size(); l3 = nld3;
        build(16'h4F50, 16'h2000, 16'h0000);
        send(0);
        wait_ld3(l3, 2000);
        n = sc3.size() - s3;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv3[s3 + i] !== 16'h2000 + 16'(i + 1)) bad++;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL gap3_third_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL gap3_third_values: got %0d bad expected 0", bad); end
    endtask

    task automatic test_reset_mid_send;
        int s0, l0, n, bad;
        do_reset;
        s0 = sc0.size(); l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        for (int k = 0; k < 500 && sc0.size() - s0 < 50; k++) begin @(negedge clke); #1; end
        rst_n = 1'b0;
        @(posedge clke); #1;
        n_cmp++;
        if ({en0, op0, busy0, ld0, el0, es0} !== 21'h0) begin
            n_fail++; $display("FAIL midrst_out0: got %h expected 0", {en0, op0, busy0, ld0, el0, es0});
        end
        n_cmp++;
        if ({en3, op3, busy3, ld3, el3, es3} !== 21'h0) begin
            n_fail++; $display("FAIL midrst_out3: got %h expected 0", {en3, op3, busy3, ld3, el3, es3});
        end
        rst_n = 1'b1;
        idle(300);
        n_cmp++; if (sc0.size() - s0 !== 50) begin n_fail++; $display("FAIL midrst_strobes: got %0d expected 50", sc0.size() - s0); end
        n_cmp++; if (nld0 - l0 !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d expected 0", nld0 - l0); end
        s0 = sc0.size(); l0 = nld0;
        build(16'h4F50, 16'h0000, 16'h0000);
        send(0);
        wait_ld0(l0, 1000);
        n = sc0.size() - s0;
        bad = 0;
        for (int i = 0; i < n; i++) if (sv0[s0 + i] !== 16'(i + 1)) bad++;
        n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 200", n); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_next_values: got %0d bad expected 0", bad); end
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_bad_header;
        test_early_eof;
        test_checksum_and_gaps;
        test_gap3_ignore;
        test_reset_mid_send;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
